// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the wait-state data memory and its
// lane-alignment helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } dmemState;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and field extraction plus
// sign/zero extension for loads on a little-endian 32-bit word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rawWord,
  output logic [3:0]  byteEn,
  output logic [31:0] storeWord,
  output logic [31:0] loadData,
  output logic        misalign
);

  logic [4:0]  byteShift_s;
  logic [4:0]  halfShift_s;
  logic [7:0]  byteVal_s;
  logic [15:0] halfVal_s;

  assign byteShift_s = {lane, 3'b000};
  assign halfShift_s = {lane[1], 4'b0000};
  assign byteVal_s   = rawWord[byteShift_s +: 8];
  assign halfVal_s   = rawWord[halfShift_s +: 16];

  // Steer store data onto its lanes and extend the selected load field.
  always_comb begin
    byteEn    = 4'b0000;
    storeWord = 32'h0000_0000;
    loadData  = 32'h0000_0000;
    misalign  = 1'b0;
    case (size)
      SIZE_B: begin
        byteEn    = 4'b0001 << lane;
        storeWord = {24'h00_0000, wdata[7:0]} << byteShift_s;
        loadData  = isUnsigned ? {24'h00_0000, byteVal_s} : {{24{byteVal_s[7]}}, byteVal_s};
      end
      SIZE_H: begin
        byteEn    = 4'b0011 << {lane[1], 1'b0};
        storeWord = {16'h0000, wdata[15:0]} << halfShift_s;
        loadData  = isUnsigned ? {16'h0000, halfVal_s} : {{16{halfVal_s[15]}}, halfVal_s};
        misalign  = lane[0];
      end
      SIZE_W: begin
        byteEn    = 4'b1111;
        storeWord = wdata;
        loadData  = rawWord;
        misalign  = (lane != 2'b00);
      end
      default: begin
        byteEn    = 4'b0000;
        storeWord = 32'h0000_0000;
        loadData  = 32'h0000_0000;
        misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: byte-addressed data memory behind a valid/ready request port
// with programmable wait states and a one-cycle response pulse.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [31:0]       mem [0:DEPTH-1];
  dmemState          state_r;
  logic [WAIT_W-1:0] cnt_r;
  logic              we_r;
  logic              uns_r;
  logic [1:0]        size_r;
  logic [31:0]       addr_r;
  logic [31:0]       wdata_r;

  logic [31:0]       rawWord_s;
  logic [31:0]       storeWord_s;
  logic [31:0]       loadData_s;
  logic [3:0]        byteEn_s;
  logic              misalign_s;
  logic              err_s;
  logic              fire_s;
  logic              memWe_s;

  assign rawWord_s = mem[addr_r[ADDR_W-1:2]];

  dmem_lane_align uAlign (
    .size      (size_r),
    .isUnsigned(uns_r),
    .lane      (addr_r[1:0]),
    .wdata     (wdata_r),
    .rawWord   (rawWord_s),
    .byteEn    (byteEn_s),
    .storeWord (storeWord_s),
    .loadData  (loadData_s),
    .misalign  (misalign_s)
  );

  // A bad request is rejected as a whole: no lane is written and data reads as zero.
  assign err_s   = misalign_s | (size_r == SIZE_ILL) | (|addr_r[31:ADDR_W]);
  assign fire_s  = (state_r == ACCESS) && (cnt_r == {WAIT_W{1'b0}});
  assign memWe_s = fire_s && we_r && !err_s;

  // Word array write port; only enabled lanes change.
  always_ff @(posedge clk) begin
    if (memWe_s) begin
      for (int k = 0; k < 4; k++) begin
        if (byteEn_s[k]) begin
          mem[addr_r[ADDR_W-1:2]][8*k +: 8] <= storeWord_s[8*k +: 8];
        end
      end
    end
  end

  // Request FSM with latched request, wait counter and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {WAIT_W{1'b0}};
      we_r      <= 1'b0;
      uns_r     <= 1'b0;
      size_r    <= SIZE_B;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_r      <= req_we;
            uns_r     <= req_unsigned;
            size_r    <= req_size;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            cnt_r     <= WAIT_W'(WAIT_CYCLES);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_r   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_r != {WAIT_W{1'b0}}) begin
            cnt_r <= cnt_r - WAIT_W'(1);
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_s;
            if (err_s || we_r) begin
              rsp_rdata <= 32'h0000_0000;
            end else begin
              rsp_rdata <= loadData_s;
            end
            state_r <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: three instances (1, 0 and 3 wait states) checked against
// a byte-array reference model with directed and random transactions.
module tb_dmem_wait_ctrl;

  localparam bit [11:0] WAITS = {4'd3, 4'd0, 4'd1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid   [3];
  logic        reqReady   [3];
  logic        reqWe      [3];
  logic [1:0]  reqSize    [3];
  logic        reqUns     [3];
  logic [31:0] reqAddr    [3];
  logic [31:0] reqWdata   [3];
  logic        rspValid   [3];
  logic [31:0] rspRdata   [3];
  logic        rspErr     [3];
  logic        busy       [3];

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model [3][1024];

  typedef struct {
    bit        we;
    bit [1:0]  sz;
    bit        uns;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] lit;
  } op_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gDut
    dmem_wait_ctrl #(.ADDR_W(10), .WAIT_CYCLES(int'(WAITS[g*4 +: 4]))) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (reqValid[g]),
      .req_ready   (reqReady[g]),
      .req_we      (reqWe[g]),
      .req_size    (reqSize[g]),
      .req_unsigned(reqUns[g]),
      .req_addr    (reqAddr[g]),
      .req_wdata   (reqWdata[g]),
      .rsp_valid   (rspValid[g]),
      .rsp_rdata   (rspRdata[g]),
      .rsp_err     (rspErr[g]),
      .busy        (busy[g])
    );
  end

  function automatic int waitOf(input int d);
    bit [11:0] w;
    w = WAITS;
    return int'(w[d*4 +: 4]);
  endfunction

  // Reference: memory is a flat byte array; access rules applied directly.
  task automatic refAccess(input int d, input bit we, input bit [1:0] sz, input bit uns,
                           input bit [31:0] a, input bit [31:0] wd,
                           output bit [31:0] rd, output bit er);
    int n;
    bit [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (a >= 32'd1024) || ((a % n) != 0);
    rd = 32'd0;
    v  = 32'd0;
    if (!er) begin
      for (int i = 0; i < n; i++) begin
        if (we) model[d][a + i] = wd[8*i +: 8];
        else    v[8*i +: 8] = model[d][a + i];
      end
      if (!we) begin
        if (n == 1)      rd = uns ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        else if (n == 2) rd = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        else             rd = v;
      end
    end
  endtask

  // Drive one request and collect the response; inputs are scrambled after accept.
  task automatic txn(input int d, input bit we, input bit [1:0] sz, input bit uns,
                     input bit [31:0] a, input bit [31:0] wd,
                     output bit [31:0] rd, output bit er, output int lat);
    int guard;
    guard = 0;
    while (reqReady[d] !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    reqValid[d] = 1'b1; reqWe[d] = we; reqSize[d] = sz; reqUns[d] = uns;
    reqAddr[d] = a; reqWdata[d] = wd;
    @(posedge clk); #1;
    reqValid[d] = 1'b0; reqWe[d] = 1'($urandom); reqSize[d] = 2'($urandom);
    reqUns[d] = 1'($urandom); reqAddr[d] = $urandom; reqWdata[d] = $urandom;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (rspValid[d] === 1'b1) begin
        lat = k;
        break;
      end
    end
    rd = rspRdata[d];
    er = rspErr[d];
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      vectors += 5;
      if (reqReady[d] !== 1'b1) begin miscompares++; $display("FAIL reset_ready dut%0d got %b want 1", d, reqReady[d]); end
      if (rspValid[d] !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid dut%0d got %b want 0", d, rspValid[d]); end
      if (busy[d] !== 1'b0) begin miscompares++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy[d]); end
      if (rspErr[d] !== 1'b0) begin miscompares++; $display("FAIL reset_err dut%0d got %b want 0", d, rspErr[d]); end
      if (rspRdata[d] !== 32'h0) begin miscompares++; $display("FAIL reset_rdata dut%0d got %h want 0", d, rspRdata[d]); end
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    bit [31:0] rd, e; bit er, ee; int lat; bit [31:0] wd;
    for (int d = 0; d < 3; d++) begin
      for (int w = 0; w < 256; w++) begin
        wd = $urandom;
        refAccess(d, 1'b1, 2'd2, 1'b0, w * 4, wd, e, ee);
        txn(d, 1'b1, 2'd2, 1'b0, w * 4, wd, rd, er, lat);
      end
    end
  endtask

  task automatic test_store_load();
    op_t tbl [8];
    bit [31:0] rd, e; bit er, ee; int lat;
    tbl[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0};
    tbl[1] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11223344};
    tbl[2] = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB, 32'h0};
    tbl[3] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11AB3344};
    tbl[4] = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'hFFFFFFAB};
    tbl[5] = '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'h000000AB};
    tbl[6] = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h00008001, 32'h0};
    tbl[7] = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0,        32'hFFFF8001};
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 9; i++) begin
        op_t op;
        op = (i < 8) ? tbl[i] : '{1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 32'h00008001};
        refAccess(d, op.we, op.sz, op.uns, op.a, op.wd, e, ee);
        txn(d, op.we, op.sz, op.uns, op.a, op.wd, rd, er, lat);
        vectors += 3;
        if (rd !== op.lit) begin miscompares++; $display("FAIL store_load_data dut%0d op%0d got %h want %h", d, i, rd, op.lit); end
        if (er !== 1'b0) begin miscompares++; $display("FAIL store_load_err dut%0d op%0d got %b want 0", d, i, er); end
        if (lat != waitOf(d) + 1) begin miscompares++; $display("FAIL store_load_latency dut%0d op%0d got %0d want %0d", d, i, lat, waitOf(d) + 1); end
      end
    end
  endtask

  task automatic test_errors();
    op_t tbl [4];
    bit [31:0] rd, e, ra [3]; bit er, ee; int lat;
    tbl[0] = '{1'b0, 2'd2, 1'b0, 32'h011, 32'h0,        32'h0};
    tbl[1] = '{1'b1, 2'd1, 1'b0, 32'h013, 32'h0000FFFF, 32'h0};
    tbl[2] = '{1'b1, 2'd3, 1'b0, 32'h010, 32'hCAFEBABE, 32'h0};
    tbl[3] = '{1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      refAccess(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, e, ee);
      txn(0, tbl[i].we, tbl[i].sz, tbl[i].uns, tbl[i].a, tbl[i].wd, rd, er, lat);
      vectors += 3;
      if (er !== 1'b1) begin miscompares++; $display("FAIL error_flag case%0d got %b want 1", i, er); end
      if (rd !== 32'h0) begin miscompares++; $display("FAIL error_rdata case%0d got %h want 0", i, rd); end
      if (lat != waitOf(0) + 1) begin miscompares++; $display("FAIL error_latency case%0d got %0d want %0d", i, lat, waitOf(0) + 1); end
    end
    ra[0] = 32'h10; ra[1] = 32'h14; ra[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      refAccess(0, 1'b0, 2'd2, 1'b0, ra[i], 32'h0, e, ee);
      txn(0, 1'b0, 2'd2, 1'b0, ra[i], 32'h0, rd, er, lat);
      vectors += 2;
      if (rd !== e) begin miscompares++; $display("FAIL error_reread addr %h got %h want %h", ra[i], rd, e); end
      if (er !== 1'b0) begin miscompares++; $display("FAIL error_reread_err addr %h got %b want 0", ra[i], er); end
    end
  endtask

  task automatic test_back_to_back(input int d);
    bit [31:0] addrs [5], exps [5];
    bit er;
    int w, nRsp, lastAcc;
    bit prevReady;
    w = waitOf(d);
    for (int i = 0; i < 5; i++) begin
      addrs[i] = 32'($urandom_range(0, 255)) * 4;
      refAccess(d, 1'b0, 2'd2, 1'b0, addrs[i], 32'h0, exps[i], er);
    end
    reqWe[d] = 1'b0; reqSize[d] = 2'd2; reqUns[d] = 1'b0; reqAddr[d] = addrs[0]; reqValid[d] = 1'b1;
    prevReady = reqReady[d];
    nRsp = 0;
    lastAcc = -1;
    for (int c = 0; c < 80 && nRsp < 5; c++) begin
      @(posedge clk); #1;
      if (prevReady && reqValid[d]) begin
        if (lastAcc >= 0) begin
          vectors++;
          if (c - lastAcc != w + 3) begin miscompares++; $display("FAIL b2b_spacing dut%0d got %0d want %0d", d, c - lastAcc, w + 3); end
        end
        lastAcc = c;
        reqAddr[d] = $urandom;
      end
      if (lastAcc >= 0) begin
        vectors++;
        if (reqReady[d] !== ((c - lastAcc) >= w + 2)) begin
          miscompares++; $display("FAIL b2b_ready dut%0d cyc %0d got %b want %b", d, c - lastAcc, reqReady[d], (c - lastAcc) >= w + 2);
        end
      end
      if (rspValid[d] === 1'b1) begin
        vectors++;
        if (rspRdata[d] !== exps[nRsp] || rspErr[d] !== 1'b0) begin
          miscompares++; $display("FAIL b2b_data dut%0d rsp%0d got %h/%b want %h/0", d, nRsp, rspRdata[d], rspErr[d], exps[nRsp]);
        end
        nRsp++;
        if (nRsp < 5) reqAddr[d] = addrs[nRsp];
        else          reqValid[d] = 1'b0;
      end
      prevReady = reqReady[d];
    end
    reqValid[d] = 1'b0;
    vectors++;
    if (nRsp != 5) begin miscompares++; $display("FAIL b2b_count dut%0d got %0d want 5", d, nRsp); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit [31:0] rd, e; bit er, ee; int lat; bit sawRsp;
    refAccess(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, e, ee);
    txn(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== e) begin miscompares++; $display("FAIL rstmid_preload got %h want %h", rd, e); end
    reqValid[2] = 1'b1; reqWe[2] = 1'b1; reqSize[2] = 2'd2; reqUns[2] = 1'b0;
    reqAddr[2] = 32'h20; reqWdata[2] = 32'hDEADBEEF;
    @(posedge clk); #1;
    reqValid[2] = 1'b0;
    vectors++;
    if (busy[2] !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy got %b want 1", busy[2]); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors += 5;
    if (reqReady[2] !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", reqReady[2]); end
    if (busy[2] !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy_clr got %b want 0", busy[2]); end
    if (rspValid[2] !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid got %b want 0", rspValid[2]); end
    if (rspRdata[2] !== 32'h0) begin miscompares++; $display("FAIL rstmid_rdata got %h want 0", rspRdata[2]); end
    if (rspErr[2] !== 1'b0) begin miscompares++; $display("FAIL rstmid_err got %b want 0", rspErr[2]); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    sawRsp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rspValid[2] === 1'b1) sawRsp = 1'b1;
    end
    vectors++;
    if (sawRsp) begin miscompares++; $display("FAIL rstmid_no_rsp got pulse want none"); end
    txn(2, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat);
    vectors++;
    if (rd !== e) begin miscompares++; $display("FAIL rstmid_old_value got %h want %h", rd, e); end
  endtask

  task automatic test_random(input int d);
    bit [31:0] rd, e, a, wd; bit er, ee, we, uns; bit [1:0] sz; int lat;
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom);
      sz  = 2'($urandom);
      uns = 1'($urandom);
      wd  = $urandom;
      a   = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 9) == 0) a = a | (32'h400 << $urandom_range(0, 21));
      refAccess(d, we, sz, uns, a, wd, e, ee);
      txn(d, we, sz, uns, a, wd, rd, er, lat);
      vectors += 3;
      if (rd !== e) begin miscompares++; $display("FAIL random_data dut%0d we%b sz%0d a %h got %h want %h", d, we, sz, a, rd, e); end
      if (er !== ee) begin miscompares++; $display("FAIL random_err dut%0d sz%0d a %h got %b want %b", d, sz, a, er, ee); end
      if (lat != waitOf(d) + 1) begin miscompares++; $display("FAIL random_latency dut%0d got %0d want %0d", d, lat, waitOf(d) + 1); end
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      reqValid[d] = 1'b0; reqWe[d] = 1'b0; reqSize[d] = 2'd0; reqUns[d] = 1'b0;
      reqAddr[d] = 32'h0; reqWdata[d] = 32'h0;
    end
    test_reset();
    test_fill();
    test_store_load();
    test_errors();
    test_back_to_back(1);
    test_back_to_back(2);
    test_reset_mid();
    for (int d = 0; d < 3; d++) test_random(d);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
